// File: rtl/noc_pkg.sv
// Types and constants shared by the NoC router blocks (input FIFO, arbiters, crossbar).
package noc_pkg;

    localparam int DATA_WIDTH_DEFAULT = 32;
    localparam int NUM_PORTS          = 5;

    typedef enum logic [2:0] {
        PORT_N = 3'd0,
        PORT_E = 3'd1,
        PORT_W = 3'd2,
        PORT_S = 3'd3,
        PORT_L = 3'd4
    } port_idx_e;

    typedef logic [DATA_WIDTH_DEFAULT-1:0] flit_t;

    // True when more than one output arbiter grants the same input in one cycle.
    function automatic logic multi_hot(input logic [NUM_PORTS-1:0] v);
        return ($countones(v) > 1);
    endfunction

endpackage

// File: rtl/noc_input_fifo_if.sv
// Upstream handshake, downstream read enables and status of one router input buffer.
interface noc_input_fifo_if
    import noc_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT,
    parameter int DEPTH      = 4
);
    localparam int PTR_W = $clog2(DEPTH);

    logic                  DRTS;
    logic [DATA_WIDTH-1:0] Data_in;
    logic                  CTS;
    logic                  read_en_N;
    logic                  read_en_E;
    logic                  read_en_W;
    logic                  read_en_S;
    logic                  read_en_L;
    logic [DATA_WIDTH-1:0] Data_out;
    logic                  empty;
    logic                  full;
    logic [PTR_W:0]        count;
    logic                  err_multi_read;

    // Master is the router fabric around the buffer; slave is the buffer itself.
    modport master (
        output DRTS, Data_in, read_en_N, read_en_E, read_en_W, read_en_S, read_en_L,
        input  CTS, Data_out, empty, full, count, err_multi_read
    );

    modport slave (
        input  DRTS, Data_in, read_en_N, read_en_E, read_en_W, read_en_S, read_en_L,
        output CTS, Data_out, empty, full, count, err_multi_read
    );

endinterface

// File: rtl/noc_fifo_hs_ctrl.sv
// RTS/CTS write handshake: registered CTS and the write strobe for the input buffer.
module noc_fifo_hs_ctrl (
    input  logic clk,
    input  logic rst,
    input  logic drts,
    input  logic full,
    output logic cts,
    output logic wr_fire
);

    logic cts_q;
    logic cts_d;

    // A write is accepted only from the idle phase, so CTS pulses for one cycle per flit.
    always_comb begin
        cts_d = drts & ~cts_q & ~full;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cts_q <= 1'b0;
        end else begin
            cts_q <= cts_d;
        end
    end

    assign cts     = cts_q;
    assign wr_fire = cts_d;

endmodule

// File: rtl/noc_input_fifo.sv
// Per-port router input buffer: RTS/CTS write side, head flit to the crossbar, pop on any grant.
module noc_input_fifo
    import noc_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT,
    parameter int DEPTH      = 4
) (
    input  logic             clk,
    input  logic             rst,
    noc_input_fifo_if.slave  bus
);

    localparam int             PTR_W   = $clog2(DEPTH);
    localparam logic [PTR_W:0] PTR_ONE = 1;

    typedef logic [DATA_WIDTH-1:0] word_t;

    logic [PTR_W:0]       wr_ptr_q;
    logic [PTR_W:0]       wr_ptr_d;
    logic [PTR_W:0]       rd_ptr_q;
    logic [PTR_W:0]       rd_ptr_d;
    logic                 err_q;
    logic                 err_d;
    word_t                mem_q [DEPTH];
    word_t                mem_d [DEPTH];

    logic                 wr_fire;
    logic                 rd_fire;
    logic                 empty_w;
    logic                 full_w;
    logic [NUM_PORTS-1:0] rd_vec;

    noc_fifo_hs_ctrl u_hs_ctrl (
        .clk     (clk),
        .rst     (rst),
        .drts    (bus.DRTS),
        .full    (full_w),
        .cts     (bus.CTS),
        .wr_fire (wr_fire)
    );

    // Bit order follows port_idx_e: N is bit 0, L is bit 4.
    assign rd_vec  = {bus.read_en_L, bus.read_en_S, bus.read_en_W, bus.read_en_E, bus.read_en_N};
    assign empty_w = (rd_ptr_q == wr_ptr_q);
    assign full_w  = (rd_ptr_q[PTR_W-1:0] == wr_ptr_q[PTR_W-1:0]) &&
                     (rd_ptr_q[PTR_W] != wr_ptr_q[PTR_W]);
    assign rd_fire = (|rd_vec) & ~empty_w;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        mem_d    = mem_q;
        err_d    = err_q | multi_hot(rd_vec);
        if (wr_fire) begin
            mem_d[wr_ptr_q[PTR_W-1:0]] = bus.Data_in;
            wr_ptr_d                   = wr_ptr_q + PTR_ONE;
        end
        if (rd_fire) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            err_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            err_q    <= err_d;
        end
    end

    // Flit storage carries no reset; stale contents are never visible while empty.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign bus.Data_out       = mem_q[rd_ptr_q[PTR_W-1:0]];
    assign bus.empty          = empty_w;
    assign bus.full           = full_w;
    assign bus.count          = wr_ptr_q - rd_ptr_q;
    assign bus.err_multi_read = err_q;

endmodule

// File: tb/tb_noc_input_fifo.sv
// Self-checking bench for noc_input_fifo: directed vector table, corner sequences and random traffic vs a queue model.
module tb_noc_input_fifo;
    import noc_pkg::*;

    localparam int DEPTH = 4;

    localparam logic [4:0] RD_NONE = 5'b00000;
    localparam logic [4:0] RD_N    = 5'b00001;
    localparam logic [4:0] RD_E    = 5'b00010;
    localparam logic [4:0] RD_W    = 5'b00100;
    localparam logic [4:0] RD_S    = 5'b01000;
    localparam logic [4:0] RD_L    = 5'b10000;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    noc_input_fifo_if #(.DATA_WIDTH(DATA_WIDTH_DEFAULT), .DEPTH(DEPTH)) bus ();

    noc_input_fifo #(.DATA_WIDTH(DATA_WIDTH_DEFAULT), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Reference model: flit queue plus the CTS phase bit and sticky error flag.
    flit_t model_q[$];
    bit    model_cts;
    bit    model_err;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        bit         r;
        bit         drts;
        flit_t      din;
        logic [4:0] rd;
        bit         e_cts;
        bit         e_empty;
        bit         e_full;
        int         e_count;
        flit_t      e_dout;
        bit         e_err;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mkVec(bit r, bit drts, flit_t din, logic [4:0] rd,
                                   bit c, bit e, bit f, int n, flit_t d, bit er);
        vec_t v;
        v.r = r; v.drts = drts; v.din = din; v.rd = rd;
        v.e_cts = c; v.e_empty = e; v.e_full = f; v.e_count = n; v.e_dout = d; v.e_err = er;
        return v;
    endfunction

    task automatic stepModel(input bit r, input bit drts, input flit_t din, input logic [4:0] rd);
        bit was_full;
        bit was_empty;
        bit wr;
        if (r) begin
            model_q.delete();
            model_cts = 1'b0;
            model_err = 1'b0;
            return;
        end
        was_full  = (model_q.size() == DEPTH);
        was_empty = (model_q.size() == 0);
        wr        = drts && !model_cts && !was_full;
        if ($countones(rd) > 1) model_err = 1'b1;
        if ((rd != 5'b0) && !was_empty) void'(model_q.pop_front());
        if (wr) model_q.push_back(din);
        model_cts = wr;
    endtask

    // Drive one cycle of inputs, advance the model, and settle just after the edge.
    task automatic applyStimulus(input bit r, input bit drts, input flit_t din, input logic [4:0] rd);
        rst         = r;
        bus.DRTS    = drts;
        bus.Data_in = din;
        {bus.read_en_L, bus.read_en_S, bus.read_en_W, bus.read_en_E, bus.read_en_N} = rd;
        stepModel(r, drts, din, rd);
        @(posedge clk);
        #1;
    endtask

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic checkOutput(input string tag);
        checkVal({tag, " CTS"},   32'(bus.CTS),            32'(model_cts));
        checkVal({tag, " empty"}, 32'(bus.empty),          32'(model_q.size() == 0));
        checkVal({tag, " full"},  32'(bus.full),           32'(model_q.size() == DEPTH));
        checkVal({tag, " count"}, 32'(bus.count),          32'(model_q.size()));
        checkVal({tag, " err"},   32'(bus.err_multi_read), 32'(model_err));
        if (model_q.size() != 0) checkVal({tag, " Data_out"}, bus.Data_out, model_q[0]);
    endtask

    task automatic checkVec(input int idx, input vec_t v);
        string t;
        t = $sformatf("vec%0d", idx);
        checkVal({t, " CTS"},   32'(bus.CTS),            32'(v.e_cts));
        checkVal({t, " empty"}, 32'(bus.empty),          32'(v.e_empty));
        checkVal({t, " full"},  32'(bus.full),           32'(v.e_full));
        checkVal({t, " count"}, 32'(bus.count),          32'(v.e_count));
        checkVal({t, " err"},   32'(bus.err_multi_read), 32'(v.e_err));
        if (!v.e_empty) checkVal({t, " Data_out"}, bus.Data_out, v.e_dout);
    endtask

    initial begin
        flit_t next_out;
        logic [4:0] rd;
        int sel;

        rst = 1'b1; bus.DRTS = 1'b0; bus.Data_in = '0;
        {bus.read_en_L, bus.read_en_S, bus.read_en_W, bus.read_en_E, bus.read_en_N} = RD_NONE;

        // Directed table: single flit, empty reads, held DRTS, multi-grant, reset clears error.
        vecs.push_back(mkVec(1, 0, 32'h0,         RD_NONE,     0, 1, 0, 0, 32'h0,         0));
        vecs.push_back(mkVec(0, 1, 32'hA5A5_0001, RD_NONE,     1, 0, 0, 1, 32'hA5A5_0001, 0));
        vecs.push_back(mkVec(0, 0, 32'h0,         RD_NONE,     0, 0, 0, 1, 32'hA5A5_0001, 0));
        vecs.push_back(mkVec(0, 0, 32'h0,         RD_E,        0, 1, 0, 0, 32'h0,         0));
        vecs.push_back(mkVec(0, 0, 32'h0,         RD_N,        0, 1, 0, 0, 32'h0,         0));
        vecs.push_back(mkVec(0, 0, 32'h0,         RD_N,        0, 1, 0, 0, 32'h0,         0));
        vecs.push_back(mkVec(0, 0, 32'h0,         RD_N,        0, 1, 0, 0, 32'h0,         0));
        vecs.push_back(mkVec(0, 1, 32'hDEAD_BEEF, RD_NONE,     1, 0, 0, 1, 32'hDEAD_BEEF, 0));
        vecs.push_back(mkVec(0, 0, 32'h0,         RD_N,        0, 1, 0, 0, 32'h0,         0));
        vecs.push_back(mkVec(0, 1, 32'h11,        RD_NONE,     1, 0, 0, 1, 32'h11,        0));
        vecs.push_back(mkVec(0, 1, 32'h11,        RD_NONE,     0, 0, 0, 1, 32'h11,        0));
        vecs.push_back(mkVec(0, 1, 32'h22,        RD_NONE,     1, 0, 0, 2, 32'h11,        0));
        vecs.push_back(mkVec(0, 0, 32'h0,         RD_NONE,     0, 0, 0, 2, 32'h11,        0));
        vecs.push_back(mkVec(0, 1, 32'h33,        RD_NONE,     1, 0, 0, 3, 32'h11,        0));
        vecs.push_back(mkVec(0, 0, 32'h0,         RD_W | RD_S, 0, 0, 0, 2, 32'h22,        1));
        vecs.push_back(mkVec(0, 0, 32'h0,         RD_NONE,     0, 0, 0, 2, 32'h22,        1));
        vecs.push_back(mkVec(1, 0, 32'h0,         RD_NONE,     0, 1, 0, 0, 32'h0,         0));

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].r, vecs[i].drts, vecs[i].din, vecs[i].rd);
            checkVec(i, vecs[i]);
        end

        // Fill to full, hold a pending fifth flit, then release it with one pop.
        for (int k = 1; k <= 4; k++) begin
            applyStimulus(0, 1, flit_t'(k), RD_NONE); checkOutput("fill");
            applyStimulus(0, 0, 32'h0, RD_NONE);      checkOutput("fill");
        end
        for (int k = 0; k < 4; k++) begin
            applyStimulus(0, 1, 32'h5, RD_NONE);
            checkVal("full hold CTS",   32'(bus.CTS),   32'd0);
            checkVal("full hold full",  32'(bus.full),  32'd1);
            checkVal("full hold count", 32'(bus.count), 32'd4);
        end
        checkVal("full head", bus.Data_out, 32'h1);
        applyStimulus(0, 1, 32'h5, RD_E);
        checkVal("pop count",    32'(bus.count), 32'd3);
        checkVal("pop full",     32'(bus.full),  32'd0);
        checkVal("pop CTS",      32'(bus.CTS),   32'd0);
        checkVal("pop Data_out", bus.Data_out,   32'h2);
        applyStimulus(0, 1, 32'h5, RD_NONE);
        checkVal("refill CTS",      32'(bus.CTS),   32'd1);
        checkVal("refill count",    32'(bus.count), 32'd4);
        checkVal("refill Data_out", bus.Data_out,   32'h2);
        applyStimulus(0, 0, 32'h0, RD_NONE); checkOutput("refill idle");
        for (int k = 2; k <= 5; k++) begin
            checkVal("drain order", bus.Data_out, flit_t'(k));
            applyStimulus(0, 0, 32'h0, RD_S); checkOutput("drain");
        end

        // Concurrent push/pop at count 2, streamed through a pointer wrap.
        applyStimulus(1, 0, 32'h0, RD_NONE); checkOutput("conc reset");
        applyStimulus(0, 1, 32'd100, RD_NONE); applyStimulus(0, 0, 32'h0, RD_NONE);
        applyStimulus(0, 1, 32'd101, RD_NONE); applyStimulus(0, 0, 32'h0, RD_NONE);
        next_out = 32'd100;
        checkVal("order", bus.Data_out, next_out); next_out++;
        applyStimulus(0, 1, 32'd102, RD_L);
        checkVal("conc count",    32'(bus.count), 32'd2);
        checkVal("conc CTS",      32'(bus.CTS),   32'd1);
        checkVal("conc Data_out", bus.Data_out,   32'd101);
        for (int i = 3; i <= 9; i++) begin
            applyStimulus(0, 0, 32'h0, RD_NONE); checkOutput("stream");
            checkVal("order", bus.Data_out, next_out); next_out++;
            applyStimulus(0, 1, flit_t'(100 + i), RD_L); checkOutput("stream");
        end
        for (int j = 0; j < 2; j++) begin
            checkVal("order", bus.Data_out, next_out); next_out++;
            applyStimulus(0, 0, 32'h0, RD_N); checkOutput("stream drain");
        end
        checkVal("stream empty", 32'(bus.empty), 32'd1);

        // Reset in the same cycle CTS would rise, with two flits stored and the error set.
        for (int k = 0; k < 3; k++) begin
            applyStimulus(0, 1, flit_t'(32'h60 + k), RD_NONE); applyStimulus(0, 0, 32'h0, RD_NONE);
        end
        applyStimulus(0, 0, 32'h0, RD_W | RD_E);
        checkVal("pre-rst count", 32'(bus.count),          32'd2);
        checkVal("pre-rst err",   32'(bus.err_multi_read), 32'd1);
        applyStimulus(1, 1, 32'h77, RD_NONE);
        checkVal("rst CTS",   32'(bus.CTS),            32'd0);
        checkVal("rst empty", 32'(bus.empty),          32'd1);
        checkVal("rst count", 32'(bus.count),          32'd0);
        checkVal("rst err",   32'(bus.err_multi_read), 32'd0);
        applyStimulus(0, 1, 32'h77, RD_NONE);
        checkVal("re-present CTS",      32'(bus.CTS), 32'd1);
        checkVal("re-present Data_out", bus.Data_out, 32'h77);

        // Random traffic against the queue model.
        applyStimulus(1, 0, 32'h0, RD_NONE);
        for (int c = 0; c < 3000; c++) begin
            sel = $urandom_range(0, 9);
            if (sel <= 4)      rd = RD_NONE;
            else if (sel <= 7) rd = 5'(1) << $urandom_range(0, 4);
            else if (sel == 8) rd = 5'($urandom);
            else               rd = RD_NONE;
            applyStimulus(($urandom_range(0, 299) == 0), 1'($urandom), flit_t'($urandom), rd);
            checkOutput("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
